// File: rtl/nios_system_descriptor_fetch.sv
// Walks a linked list of 4-word DMA descriptors and hands each to the DMA engine.
// Define DESC_FETCH_WRITEBACK_EN to write the OWN-cleared ctrl byte back after accept.
module nios_system_descriptor_fetch #(
  parameter int ADDR_W   = 10,
  parameter int MAX_DESC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  output logic              avm_clken,
  input  logic [31:0]       avm_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [31:0]       desc_len,
  output logic [31:0]       desc_ctrl
);

  localparam int CNT_W = $clog2(MAX_DESC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_PRESENT, S_WB
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic              adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = head_addr;
          count_d = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // read data lags the issued address by one cycle
        idx_d = idx_q + 3'd1;
        case (idx_q)
          3'd1: src_d = avm_readdata;
          3'd2: dst_d = avm_readdata;
          3'd3: len_d = avm_readdata;
          3'd4: begin
            ctrl_d  = avm_readdata;
            state_d = S_CHECK;
          end
          default: ;
        endcase
      end
      S_CHECK: begin
        if (!ctrl_q[30] || count_q == CNT_W'(MAX_DESC)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (desc_ready) begin
`ifdef DESC_FETCH_WRITEBACK_EN
          state_d = S_WB;
`else
          adv = 1'b1;
`endif
        end
      end
      S_WB: adv = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (ctrl_q[31]) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        cur_d   = ctrl_q[ADDR_W-1:0];
        idx_d   = '0;
        state_d = S_FETCH;
      end
    end
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    desc_valid     = (state_q == S_PRESENT);
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = 4'hF;
    avm_writedata  = '0;
    if (state_q == S_FETCH && idx_q < 3'd4) begin
      avm_chipselect = 1'b1;
      avm_address    = cur_q + ADDR_W'(idx_q);
    end
`ifdef DESC_FETCH_WRITEBACK_EN
    if (state_q == S_WB) begin
      avm_chipselect = 1'b1;
      avm_write      = 1'b1;
      avm_address    = cur_q + ADDR_W'(3);
      avm_byteenable = 4'b1000;
      avm_writedata  = {ctrl_q[31], 1'b0, ctrl_q[29:0]};
    end
`endif
  end

  assign avm_clken = 1'b1;
  assign done      = done_q;
  assign error     = err_q;
  assign desc_src  = src_q;
  assign desc_dst  = dst_q;
  assign desc_len  = len_q;
  assign desc_ctrl = ctrl_q;

endmodule

// File: tb/tb_nios_system_descriptor_fetch.sv
// Bench for nios_system_descriptor_fetch: directed and random descriptor walks
// checked against a list-walking reference model of descriptor memory.
module tb_nios_system_descriptor_fetch;

`ifdef DESC_FETCH_WRITEBACK_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  head_addr = '0;
  logic        busy, done, error;
  logic [9:0]  avm_address;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] rdata = '0;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [31:0] desc_src, desc_dst, desc_len, desc_ctrl;

  nios_system_descriptor_fetch dut (
    .clk(clk), .reset(reset), .start(start), .head_addr(head_addr),
    .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .avm_readdata(rdata), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .desc_ctrl(desc_ctrl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // descriptor memory: 1-cycle read latency, junk when not reading
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (avm_chipselect && avm_write) begin
      for (int b = 0; b < 4; b++)
        if (avm_byteenable[b])
          mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
    end
    if (avm_chipselect && !avm_write) rdata <= mem[avm_address];
    else rdata <= $urandom;
  end

  logic [127:0] acc_q[$];
  int           acc_cyc[$];
  logic [9:0]   rd_q[$];
  logic [45:0]  wr_q[$];
  int           first_valid, done_n, done_cyc, unstable;
  logic         hold = 1'b0;
  logic [127:0] held;

  always @(negedge clk) begin
    if (avm_chipselect && !avm_write) rd_q.push_back(avm_address);
    if (avm_chipselect && avm_write)
      wr_q.push_back({avm_address, avm_byteenable, avm_writedata});
    if (desc_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (hold && {desc_src, desc_dst, desc_len, desc_ctrl} !== held)
        unstable++;
      if (desc_ready) begin
        acc_q.push_back({desc_src, desc_dst, desc_len, desc_ctrl});
        acc_cyc.push_back(cyc);
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = {desc_src, desc_dst, desc_len, desc_ctrl};
      end
    end else hold = 1'b0;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [191:0] got,
                     input logic [191:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_desc(input logic [9:0] a, input logic [31:0] s,
                           input logic [31:0] d, input logic [31:0] l,
                           input logic [31:0] c);
    load_word(a, s);
    load_word(a + 10'd1, d);
    load_word(a + 10'd2, l);
    load_word(a + 10'd3, c);
  endtask

  // reference: follow next pointers from head using the list rules
  logic [127:0] exp_acc[$];
  logic [9:0]   exp_rd[$];
  logic         exp_done, exp_err;

  task automatic model(input logic [9:0] head);
    logic [9:0]  cur;
    logic [31:0] w [4];
    int n;
    cur = head;
    n = 0;
    exp_acc.delete();
    exp_rd.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    while (1) begin
      for (int k = 0; k < 4; k++) begin
        exp_rd.push_back(cur + 10'(k));
        w[k] = ref_mem[cur + 10'(k)];
      end
      if (!w[3][30] || n == 256) begin
        exp_err = 1'b1;
        break;
      end
      exp_acc.push_back({w[0], w[1], w[2], w[3]});
      n++;
`ifdef DESC_FETCH_WRITEBACK_EN
      ref_mem[cur + 10'd3][30] = 1'b0;
`endif
      if (w[3][31]) begin
        exp_done = 1'b1;
        break;
      end
      cur = w[3][9:0];
    end
  endtask

  int start_cyc;

  task automatic walk(input logic [9:0] head, input int stall_idx,
                      input int stall_len, input bit rnd, input int spur_at);
    int stall_cnt;
    int post;
    stall_cnt = 0;
    post = 0;
    acc_q.delete();
    acc_cyc.delete();
    rd_q.delete();
    wr_q.delete();
    first_valid = -1;
    done_n = 0;
    done_cyc = -1;
    unstable = 0;
    start = 1'b1;
    head_addr = head;
    desc_ready = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("error cleared by start", error, 0);
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin
        post++;
        if (post > 3) break;
      end
      start = (i == spur_at);
      head_addr = start ? 10'h155 : head;
      if (desc_valid && acc_q.size() == stall_idx && stall_cnt < stall_len) begin
        desc_ready = 1'b0;
        stall_cnt++;
      end else begin
        desc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    desc_ready = 1'b0;
  endtask

  task automatic verify(input string tag);
    int bad;
    chk({tag, " busy/timeout"}, busy, 0);
    chk({tag, " accepts"}, acc_q.size(), exp_acc.size());
    bad = 0;
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      if (acc_q[i] !== exp_acc[i]) bad++;
    chk({tag, " fields"}, bad, 0);
    chk({tag, " reads"}, rd_q.size(), exp_rd.size());
    bad = 0;
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      if (rd_q[i] !== exp_rd[i]) bad++;
    chk({tag, " read addrs"}, bad, 0);
    chk({tag, " done pulses"}, done_n, int'(exp_done));
    chk({tag, " error"}, error, exp_err);
    chk({tag, " stable"}, unstable, 0);
`ifdef DESC_FETCH_WRITEBACK_EN
    chk({tag, " writes"}, wr_q.size(), exp_acc.size());
`else
    chk({tag, " writes"}, wr_q.size(), 0);
`endif
  endtask

  logic [191:0] rst_vec;
  logic [191:0] got_vec;

  always_comb begin
    got_vec = {11'd0, busy, done, error, desc_valid, avm_chipselect,
               avm_write, avm_address, avm_byteenable, avm_writedata,
               desc_src, desc_dst, desc_len, desc_ctrl, avm_clken};
  end

  initial begin
    int a0;
    logic [45:0] w0;
    logic [9:0]  slot [5];
    int n;
    rst_vec = {11'd0, 6'b0, 10'h000, 4'hF, 32'd0, 128'd0, 1'b1};

    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) load_word(10'(i), 32'd0);
    @(negedge clk);
    chk("reset outputs", got_vec, rst_vec);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single descriptor
    load_desc(10'h010, 32'h1000, 32'h2000, 32'h40, 32'hC000_0000);
    model(10'h010);
    walk(10'h010, -1, 0, 1'b0, -1);
    verify("t1");
    chk("t1 latency", first_valid - start_cyc, 7);
    a0 = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
    chk("t1 done latency", done_cyc - a0, DONE_LAT);
`ifdef DESC_FETCH_WRITEBACK_EN
    w0 = (wr_q.size() > 0) ? wr_q[0] : '0;
    chk("t6 writeback", {w0[45:36], w0[35:32], w0[31:24]},
        {10'h013, 4'b1000, 8'h80});
`endif

    // 2: three-descriptor chain, 2nd stalled, spurious start ignored
    load_desc(10'h010, $urandom, $urandom, $urandom, 32'h4000_0020);
    load_desc(10'h020, $urandom, $urandom, $urandom, 32'h4000_0030);
    load_desc(10'h030, $urandom, $urandom, $urandom, 32'hC000_0000);
    model(10'h010);
    walk(10'h010, 1, 5, 1'b0, 8);
    verify("t2");

    // 3: wrap around the top of memory
    load_desc(10'h3FE, $urandom, $urandom, $urandom, 32'hC000_0000);
    model(10'h3FE);
    walk(10'h3FE, -1, 0, 1'b1, -1);
    verify("t3");

    // 4: second descriptor not owned by hardware
    load_desc(10'h040, $urandom, $urandom, $urandom, 32'h4000_0050);
    load_desc(10'h050, $urandom, $urandom, $urandom, 32'h0000_0030);
    model(10'h040);
    walk(10'h040, -1, 0, 1'b0, -1);
    verify("t4");
    repeat (5) @(posedge clk);
    #1;
    chk("t4 error sticky", error, 1);

    // 5: self-loop bounded by the descriptor-count guard
    load_desc(10'h010, $urandom, $urandom, $urandom, 32'h4000_0010);
    model(10'h010);
    walk(10'h010, -1, 0, 1'b0, -1);
    verify("t5");

    // random chains with random ready, last round may hit an unowned node
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) slot[i] = 10'h100 + 10'(r * 64) + 10'(i * 8);
      for (int i = 0; i < n; i++) begin
        logic own;
        logic last;
        own = !(r == 3 && i == n - 1 && n > 1);
        last = (i == n - 1);
        load_desc(slot[i], $urandom, $urandom, $urandom,
                  {last, own, 20'($urandom), last ? 10'($urandom) : slot[i + 1]});
      end
      model(slot[0]);
      walk(slot[0], -1, 0, 1'b1, -1);
      verify($sformatf("rnd%0d", r));
    end

    // 6: reset in the middle of a fetch
    load_desc(10'h010, 32'h1000, 32'h2000, 32'h40, 32'hC000_0000);
    start = 1'b1;
    head_addr = 10'h010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6 reset mid-fetch", got_vec, rst_vec);
    @(negedge clk);
    chk("t6 idle after reset", got_vec, rst_vec);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
